// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe -- registered execute stage of the 5-stage MIPS pipeline.
//
// Computes the ALU result, branch target (npc + imm), zero flag and
// destination register, and captures them in the EX/MEM pipeline register.
// MUL (R-type funct 011000) runs on an iterative shift-add multiplier that
// performs one iteration per cycle and holds the stage busy until the result
// is handed to MEM.
//
// Optional build macro: EX_FWD_EN adds operand forwarding muxes and the ports
// fwd_a_sel, fwd_b_sel, fwd_mem_data, fwd_wb_data.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   id_valid          ID/EX holds a valid instruction
//   ex_busy           stage cannot accept (multiply in progress)
//   mem_stall         MEM cannot take a result; EX/MEM register holds
//   flush             kill accepted/in-flight instruction
//   wb_ctl_in/m_ctl_in  control passed through to EX/MEM
//   ex_ctl_in         [3] ALUSrc, [2:1] ALUOp, [0] RegDst
//   npc, rdata1, rdata2, imm, rt_addr, rd_addr  ID/EX fields
//   mem_valid, wb_ctl_out, m_ctl_out, add_result, zero, alu_result,
//   rdata2_out, dest_addr                       EX/MEM register outputs
module ex_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MUL_CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    output logic                  ex_busy,
    input  logic                  mem_stall,
    input  logic                  flush,
    input  logic [1:0]            wb_ctl_in,
    input  logic [2:0]            m_ctl_in,
    input  logic [3:0]            ex_ctl_in,
    input  logic [DATA_W-1:0]     npc,
    input  logic [DATA_W-1:0]     rdata1,
    input  logic [DATA_W-1:0]     rdata2,
    input  logic [DATA_W-1:0]     imm,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  mem_valid,
    output logic [1:0]            wb_ctl_out,
    output logic [2:0]            m_ctl_out,
    output logic [DATA_W-1:0]     add_result,
    output logic                  zero,
    output logic [DATA_W-1:0]     alu_result,
    output logic [DATA_W-1:0]     rdata2_out,
    output logic [REG_ADDR_W-1:0] dest_addr
`ifdef EX_FWD_EN
    ,
    input  logic [1:0]            fwd_a_sel,
    input  logic [1:0]            fwd_b_sel,
    input  logic [DATA_W-1:0]     fwd_mem_data,
    input  logic [DATA_W-1:0]     fwd_wb_data
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011000;

    // Last iteration index: DATA_W iterations numbered 0 .. DATA_W-1.
    localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(DATA_W - 1);

    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    ex_busy_r;
    logic [MUL_CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]       mcand_r;
    logic [DATA_W-1:0]       mplier_r;
    logic [DATA_W-1:0]       prod_r;

    // Instruction context captured at MUL accept, replayed when DONE loads.
    logic [1:0]              mul_wb_r;
    logic [2:0]              mul_m_r;
    logic [DATA_W-1:0]       mul_target_r;
    logic [DATA_W-1:0]       mul_store_r;
    logic [REG_ADDR_W-1:0]   mul_dest_r;

    logic [DATA_W-1:0]       fwd_a_s;
    logic [DATA_W-1:0]       fwd_b_s;
    logic [DATA_W-1:0]       op_b_s;
    logic [DATA_W-1:0]       alu_s;
    logic [DATA_W-1:0]       target_s;
    logic [REG_ADDR_W-1:0]   dest_s;
    logic                    is_mul_s;
    logic                    accept_s;
    logic                    mul_start_s;

    logic                    mem_valid_r;
    logic [1:0]              wb_ctl_r;
    logic [2:0]              m_ctl_r;
    logic [DATA_W-1:0]       add_result_r;
    logic                    zero_r;
    logic [DATA_W-1:0]       alu_result_r;
    logic [DATA_W-1:0]       rdata2_r;
    logic [REG_ADDR_W-1:0]   dest_r;

`ifdef EX_FWD_EN
    // Forwarding muxes: 10 = MEM stage, 01 = WB stage, else register file.
    always_comb begin
        fwd_a_s = rdata1;
        fwd_b_s = rdata2;
        case (fwd_a_sel)
            2'b10:   fwd_a_s = fwd_mem_data;
            2'b01:   fwd_a_s = fwd_wb_data;
            default: fwd_a_s = rdata1;
        endcase
        case (fwd_b_sel)
            2'b10:   fwd_b_s = fwd_mem_data;
            2'b01:   fwd_b_s = fwd_wb_data;
            default: fwd_b_s = rdata2;
        endcase
    end
`else
    // Operands come straight from the register file.
    always_comb begin
        fwd_a_s = rdata1;
        fwd_b_s = rdata2;
    end
`endif

    // ALUSrc mux, RegDst mux and branch target adder.
    always_comb begin
        op_b_s   = ex_ctl_in[3] ? imm : fwd_b_s;
        dest_s   = ex_ctl_in[0] ? rd_addr : rt_addr;
        target_s = npc + imm;
    end

    // ALU decode; MUL only flags the multiplier, its ALU value is unused.
    always_comb begin
        alu_s    = fwd_a_s + op_b_s;
        is_mul_s = 1'b0;
        case (ex_ctl_in[2:1])
            2'b00: alu_s = fwd_a_s + op_b_s;
            2'b01: alu_s = fwd_a_s - op_b_s;
            2'b10: begin
                case (imm[5:0])
                    FN_ADD: alu_s = fwd_a_s + op_b_s;
                    FN_SUB: alu_s = fwd_a_s - op_b_s;
                    FN_AND: alu_s = fwd_a_s & op_b_s;
                    FN_OR:  alu_s = fwd_a_s | op_b_s;
                    FN_NOR: alu_s = ~(fwd_a_s | op_b_s);
                    FN_SLT: alu_s = ($signed(fwd_a_s) < $signed(op_b_s)) ? DATA_ONE : DATA_ZERO;
                    FN_MUL: begin
                        alu_s    = fwd_a_s + op_b_s;
                        is_mul_s = 1'b1;
                    end
                    default: alu_s = fwd_a_s + op_b_s;
                endcase
            end
            2'b11:   alu_s = fwd_a_s | op_b_s;
            default: alu_s = fwd_a_s + op_b_s;
        endcase
    end

    // Accept handshake and multiplier launch condition.
    always_comb begin
        accept_s    = id_valid & ~ex_busy_r & ~mem_stall & ~flush;
        mul_start_s = accept_s & is_mul_s & (state_r == ST_IDLE);
    end

    // Multiplier FSM next state; flush overrides everything.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_next_s = mul_start_s ? ST_MUL : ST_IDLE;
                ST_MUL:  state_next_s = (cnt_r == CNT_LAST) ? ST_DONE : ST_MUL;
                ST_DONE: state_next_s = mem_stall ? ST_DONE : ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // FSM state register; ex_busy is registered from the next state so it
    // rises the cycle after a MUL accept and falls on the DONE hand-off edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ex_busy_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            ex_busy_r <= (state_next_s != ST_IDLE);
        end
    end

    // Shift-add multiplier datapath and captured instruction context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= {MUL_CNT_W{1'b0}};
            mcand_r      <= DATA_ZERO;
            mplier_r     <= DATA_ZERO;
            prod_r       <= DATA_ZERO;
            mul_wb_r     <= 2'b00;
            mul_m_r      <= 3'b000;
            mul_target_r <= DATA_ZERO;
            mul_store_r  <= DATA_ZERO;
            mul_dest_r   <= {REG_ADDR_W{1'b0}};
        end else if (flush) begin
            cnt_r <= {MUL_CNT_W{1'b0}};
        end else if (mul_start_s) begin
            cnt_r        <= {MUL_CNT_W{1'b0}};
            mcand_r      <= fwd_a_s;
            mplier_r     <= op_b_s;
            prod_r       <= DATA_ZERO;
            mul_wb_r     <= wb_ctl_in;
            mul_m_r      <= m_ctl_in;
            mul_target_r <= target_s;
            mul_store_r  <= fwd_b_s;
            mul_dest_r   <= dest_s;
        end else if (state_r == ST_MUL) begin
            // Only the low DATA_W product bits are kept, so bits shifted out
            // of the multiplicand never matter.
            prod_r   <= prod_r + (mplier_r[0] ? mcand_r : DATA_ZERO);
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + {{(MUL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // EX/MEM pipeline register: flush > stall hold > MUL hand-off >
    // single-cycle accept > bubble (controls cleared, data left as is).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_r  <= 1'b0;
            wb_ctl_r     <= 2'b00;
            m_ctl_r      <= 3'b000;
            add_result_r <= DATA_ZERO;
            zero_r       <= 1'b0;
            alu_result_r <= DATA_ZERO;
            rdata2_r     <= DATA_ZERO;
            dest_r       <= {REG_ADDR_W{1'b0}};
        end else if (flush) begin
            mem_valid_r <= 1'b0;
            wb_ctl_r    <= 2'b00;
            m_ctl_r     <= 3'b000;
        end else if (mem_stall) begin
            mem_valid_r <= mem_valid_r;
        end else if (state_r == ST_DONE) begin
            mem_valid_r  <= 1'b1;
            wb_ctl_r     <= mul_wb_r;
            m_ctl_r      <= mul_m_r;
            add_result_r <= mul_target_r;
            zero_r       <= (prod_r == DATA_ZERO);
            alu_result_r <= prod_r;
            rdata2_r     <= mul_store_r;
            dest_r       <= mul_dest_r;
        end else if (accept_s && !is_mul_s) begin
            mem_valid_r  <= 1'b1;
            wb_ctl_r     <= wb_ctl_in;
            m_ctl_r      <= m_ctl_in;
            add_result_r <= target_s;
            zero_r       <= (alu_s == DATA_ZERO);
            alu_result_r <= alu_s;
            rdata2_r     <= fwd_b_s;
            dest_r       <= dest_s;
        end else begin
            mem_valid_r <= 1'b0;
            wb_ctl_r    <= 2'b00;
            m_ctl_r     <= 3'b000;
        end
    end

    assign ex_busy    = ex_busy_r;
    assign mem_valid  = mem_valid_r;
    assign wb_ctl_out = wb_ctl_r;
    assign m_ctl_out  = m_ctl_r;
    assign add_result = add_result_r;
    assign zero       = zero_r;
    assign alu_result = alu_result_r;
    assign rdata2_out = rdata2_r;
    assign dest_addr  = dest_r;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Testbench for ex_stage_pipe: directed vectors with hand-computed results.
// Stimulus pushes expected EX/MEM contents into a queue; a monitor pops and
// compares each time the EX/MEM register loads a valid instruction, and
// checks that held values stay put while MEM stalls.
module tb_ex_stage_pipe;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] add;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  dest;
    } res_t;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, ex_busy, mem_stall, flush;
    logic [1:0]  wb_ctl_in;
    logic [2:0]  m_ctl_in;
    logic [3:0]  ex_ctl_in;
    logic [31:0] npc, rdata1, rdata2, imm;
    logic [4:0]  rt_addr, rd_addr;
    logic        mem_valid, zero;
    logic [1:0]  wb_ctl_out;
    logic [2:0]  m_ctl_out;
    logic [31:0] add_result, alu_result, rdata2_out;
    logic [4:0]  dest_addr;
`ifdef EX_FWD_EN
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] fwd_mem_data, fwd_wb_data;
`endif

    int   checks   = 0;
    int   failures = 0;
    res_t q[$];
    res_t last_exp;
    logic stall_q = 1'b0;

    ex_stage_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .ex_busy(ex_busy),
        .mem_stall(mem_stall), .flush(flush), .wb_ctl_in(wb_ctl_in),
        .m_ctl_in(m_ctl_in), .ex_ctl_in(ex_ctl_in), .npc(npc),
        .rdata1(rdata1), .rdata2(rdata2), .imm(imm), .rt_addr(rt_addr),
        .rd_addr(rd_addr), .mem_valid(mem_valid), .wb_ctl_out(wb_ctl_out),
        .m_ctl_out(m_ctl_out), .add_result(add_result), .zero(zero),
        .alu_result(alu_result), .rdata2_out(rdata2_out), .dest_addr(dest_addr)
`ifdef EX_FWD_EN
        , .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data)
`endif
    );

    always #5 clk = ~clk;

    // Register mem_stall as seen by the DUT at each active edge.
    always @(posedge clk) stall_q <= mem_stall;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic res_t dut_out();
        res_t r;
        r = '{wb: wb_ctl_out, m: m_ctl_out, add: add_result, zero: zero,
              alu: alu_result, rd2: rdata2_out, dest: dest_addr};
        return r;
    endfunction

    // Monitor: a fresh load (no stall at the last edge) pops the scoreboard,
    // a held valid result must still equal the last popped entry.
    always @(negedge clk) begin
        if (rst_n && mem_valid) begin
            if (!stall_q) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=%h expected=none", dut_out());
                end else begin
                    last_exp = q.pop_front();
                    chk("sb_result", 128'(dut_out()), 128'(last_exp));
                end
            end else begin
                chk("sb_hold", 128'(dut_out()), 128'(last_exp));
            end
        end
    end

    function automatic vec_t mkv(input logic [3:0] ctl, input logic [1:0] wb, input logic [2:0] m,
                                 input logic [31:0] npc_v, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm_v, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic [31:0] tgt);
        vec_t v;
        v.ctl = ctl; v.npc = npc_v; v.a = a; v.b = b; v.imm = imm_v; v.rt = rt; v.rd = rd;
        v.exp = '{wb: wb, m: m, add: tgt, zero: (alu == 32'd0), alu: alu, rd2: b,
                  dest: (ctl[0] ? rd : rt)};
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for ex_busy low, offer v for one cycle; called at posedge+1.
    task automatic issue(input vec_t v, input bit push);
        int n = 0;
        while (ex_busy && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout actual=%0d expected<200", n);
        end
        id_valid = 1'b1; mem_stall = 1'b0; flush = 1'b0;
        ex_ctl_in = v.ctl; wb_ctl_in = v.exp.wb; m_ctl_in = v.exp.m;
        npc = v.npc; rdata1 = v.a; rdata2 = v.b; imm = v.imm;
        rt_addr = v.rt; rd_addr = v.rd;
        if (push) q.push_back(v.exp);
        tick(1);
        id_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (ex_busy && n < 100) begin
            tick(1);
            n++;
        end
    endtask

    vec_t sc[11];
    vec_t v;
    int   n;

    initial begin
        sc[0]  = mkv(4'b0101, 2'b10, 3'b000, 32'h10, 32'd5, 32'd7, 32'h20, 5'd9, 5'd3, 32'd12, 32'h30);
        sc[1]  = mkv(4'b0010, 2'b00, 3'b001, 32'h40, 32'h1234, 32'h1234, 32'hFFFF_FFFE, 5'd2, 5'd7, 32'd0, 32'h3E);
        sc[2]  = mkv(4'b0101, 2'b10, 3'b000, 32'h44, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd8, 5'd4, 32'd1, 32'h6E);
        sc[3]  = mkv(4'b1110, 2'b10, 3'b000, 32'h48, 32'h0F, 32'h55, 32'hF0, 5'd5, 5'd12, 32'hFF, 32'h138);
        sc[4]  = mkv(4'b0101, 2'b10, 3'b000, 32'h4C, 32'd3, 32'd5, 32'h22, 5'd1, 5'd6, 32'hFFFF_FFFE, 32'h6E);
        sc[5]  = mkv(4'b0101, 2'b10, 3'b000, 32'h0, 32'hF0F0, 32'h0FF0, 32'h24, 5'd1, 5'd7, 32'h00F0, 32'h24);
        sc[6]  = mkv(4'b0101, 2'b10, 3'b000, 32'h0, 32'hF0F0, 32'h0F0F, 32'h27, 5'd1, 5'd8, 32'hFFFF_0000, 32'h27);
        sc[7]  = mkv(4'b0101, 2'b10, 3'b000, 32'h0, 32'd1, 32'd2, 32'h3F, 5'd1, 5'd9, 32'd3, 32'h3F);
        sc[8]  = mkv(4'b1000, 2'b11, 3'b010, 32'h4, 32'h100, 32'hAA, 32'hFFFF_FFFC, 5'd10, 5'd11, 32'hFC, 32'h0);
        sc[9]  = mkv(4'b0010, 2'b00, 3'b001, 32'h0, 32'd0, 32'd1, 32'h10, 5'd13, 5'd14, 32'hFFFF_FFFF, 32'h10);
        sc[10] = mkv(4'b0101, 2'b10, 3'b000, 32'h0, 32'd1, 32'hFFFF_FFFF, 32'h2A, 5'd1, 5'd15, 32'd0, 32'h2A);

        rst_n = 1'b0; id_valid = 1'b0; mem_stall = 1'b0; flush = 1'b0;
        wb_ctl_in = 2'b00; m_ctl_in = 3'b000; ex_ctl_in = 4'b0000;
        npc = 32'd0; rdata1 = 32'd0; rdata2 = 32'd0; imm = 32'd0;
        rt_addr = 5'd0; rd_addr = 5'd0;
`ifdef EX_FWD_EN
        fwd_a_sel = 2'b00; fwd_b_sel = 2'b00; fwd_mem_data = 32'd0; fwd_wb_data = 32'd0;
`endif
        tick(3);
        chk("reset_state", {dut_out(), mem_valid, ex_busy}, 128'd0);
        rst_n = 1'b1;
        tick(1);

        // Single-cycle ops: result must be valid one edge after accept.
        for (int i = 0; i < 11; i++) begin
            issue(sc[i], 1'b1);
            chk($sformatf("latency_%0d", i), {127'd0, mem_valid}, 128'd1);
        end
        tick(1);
        chk("bubble", {123'd0, mem_valid, wb_ctl_out, m_ctl_out}, 128'd0);

        // Hold under mem_stall, then bubble after release.
        issue(sc[0], 1'b1);
        mem_stall = 1'b1;
        tick(2);
        mem_stall = 1'b0;
        tick(1);
        chk("bubble_after_stall", {127'd0, mem_valid}, 128'd0);

        // MUL 6*7: busy window, single result.
        issue(mkv(4'b0101, 2'b01, 3'b000, 32'h80, 32'd6, 32'd7, 32'h18, 5'd1, 5'd11, 32'd42, 32'h98), 1'b1);
        wait_idle(n);
        chk("mul_busy_cycles", {127'd0, (n >= 32 && n <= 35)}, 128'd1);
        tick(1);
        chk("mul_once", {127'd0, mem_valid}, 128'd0);

        // MUL 0xFFFFFFFF*2 with mem_stall held through DONE.
        issue(mkv(4'b0101, 2'b10, 3'b000, 32'h0, 32'hFFFF_FFFF, 32'd2, 32'h18, 5'd1, 5'd12, 32'hFFFF_FFFE, 32'h18), 1'b1);
        tick(20);
        mem_stall = 1'b1;
        tick(20);
        chk("mul_stall_wait", {126'd0, ex_busy, mem_valid}, 128'd2);
        mem_stall = 1'b0;
        wait_idle(n);
        chk("mul_stall_release", {127'd0, (n < 100)}, 128'd1);
        tick(1);

        // Flush during MUL while a new instruction is offered.
        issue(mkv(4'b0101, 2'b10, 3'b000, 32'h0, 32'd3, 32'd3, 32'h18, 5'd1, 5'd2, 32'd9, 32'h18), 1'b0);
        tick(5);
        flush = 1'b1; id_valid = 1'b1;
        tick(1);
        flush = 1'b0; id_valid = 1'b0;
        chk("flush_mul", {122'd0, mem_valid, ex_busy, wb_ctl_out, m_ctl_out}, 128'd0);

        // Flush in IDLE drops the offered instruction and kills the prior one.
        issue(sc[3], 1'b1);
        flush = 1'b1; id_valid = 1'b1;
        tick(1);
        flush = 1'b0; id_valid = 1'b0;
        chk("flush_drop", {122'd0, mem_valid, ex_busy, wb_ctl_out, m_ctl_out}, 128'd0);

        // Flush together with mem_stall resolves as flush.
        issue(sc[2], 1'b1);
        flush = 1'b1; mem_stall = 1'b1; id_valid = 1'b1;
        tick(1);
        flush = 1'b0; mem_stall = 1'b0; id_valid = 1'b0;
        chk("flush_stall", {122'd0, mem_valid, ex_busy, wb_ctl_out, m_ctl_out}, 128'd0);

        // Flush during MUL with mem_stall.
        issue(mkv(4'b0101, 2'b10, 3'b000, 32'h0, 32'd4, 32'd4, 32'h18, 5'd1, 5'd2, 32'd16, 32'h18), 1'b0);
        tick(3);
        flush = 1'b1; mem_stall = 1'b1;
        tick(1);
        flush = 1'b0; mem_stall = 1'b0;
        chk("flush_mul_stall", {122'd0, mem_valid, ex_busy, wb_ctl_out, m_ctl_out}, 128'd0);

        // Pipeline works again after a flush.
        issue(sc[4], 1'b1);
        tick(1);

        // Asynchronous reset in the middle of a multiply.
        issue(sc[8], 1'b1);
        issue(mkv(4'b0101, 2'b10, 3'b000, 32'h0, 32'd5, 32'd5, 32'h18, 5'd1, 5'd2, 32'd25, 32'h18), 1'b0);
        tick(10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_mul", {dut_out(), mem_valid, ex_busy}, 128'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        issue(sc[6], 1'b1);

`ifdef EX_FWD_EN
        fwd_a_sel = 2'b10; fwd_mem_data = 32'd100;
        issue(mkv(4'b0101, 2'b10, 3'b000, 32'h0, 32'd999, 32'd1, 32'h20, 5'd1, 5'd3, 32'd101, 32'h20), 1'b1);
        fwd_a_sel = 2'b00; fwd_b_sel = 2'b01; fwd_wb_data = 32'd20;
        v = mkv(4'b0101, 2'b10, 3'b000, 32'h0, 32'd3, 32'd20, 32'h20, 5'd1, 5'd3, 32'd23, 32'h20);
        v.b = 32'd777;
        issue(v, 1'b1);
        fwd_b_sel = 2'b00;
`endif

        // Drain scoreboard.
        n = 0;
        while (q.size() != 0 && n < 50) begin
            tick(1);
            n++;
        end
        tick(2);
        chk("sb_drained", 128'(q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
Registered execute stage for the 5-stage MIPS pipeline. Parametrised successor of the combinational EX block: it computes the ALU result, branch target, zero flag and destination register, then captures them in an internal EX/MEM pipeline register. It adds an iterative shift-add multiplier (FSM), upstream/downstream stall handshake and flush. It sits between the ID/EX register and the MEM stage.

Parameters:
DATA_W, 32, datapath width (ALU, operands, PC, immediate)
REG_ADDR_W, 5, register-file address width
MUL_CNT_W, 6, multiplier iteration counter width; must satisfy 2^MUL_CNT_W > DATA_W

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID/EX holds a valid instruction
ex_busy  out  1  stage cannot accept; upstream holds ID/EX
mem_stall  in  1  MEM stage cannot take a result; output register holds
flush  in  1  kill the in-flight and accepted instruction (branch taken)
wb_ctl_in  in  2  WB control, passed through
m_ctl_in  in  3  MEM control, passed through
ex_ctl_in  in  4  [3] ALUSrc (1=imm), [2:1] ALUOp, [0] RegDst (1=rd)
npc  in  DATA_W  PC+1 (word addressed)
rdata1  in  DATA_W  operand A
rdata2  in  DATA_W  operand B / store data
imm  in  DATA_W  sign-extended immediate; [5:0] is funct
rt_addr  in  REG_ADDR_W  instr[20:16]
rd_addr  in  REG_ADDR_W  instr[15:11]
mem_valid  out  1  EX/MEM register holds a valid instruction
wb_ctl_out  out  2  registered
m_ctl_out  out  3  registered
add_result  out  DATA_W  registered branch target = npc + imm
zero  out  1  registered (alu_result == 0)
alu_result  out  DATA_W  registered
rdata2_out  out  DATA_W  registered store data
dest_addr  out  REG_ADDR_W  registered destination register

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM IDLE, counter 0, ex_busy 0.
- Accept = id_valid & ~ex_busy & ~mem_stall & ~flush.
- Operand B = ex_ctl_in[3] ? imm : rdata2. dest = ex_ctl_in[0] ? rd_addr : rt_addr.
- ALU decode: ALUOp 00 ADD; 01 SUB; 10 by funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT (signed, result 1/0), 011000 MUL; unknown funct -> ADD. ALUOp 11 -> OR (ori).
- Arithmetic wraps modulo 2^DATA_W; no overflow trap. add_result = npc + imm, wraps.
- Single-cycle ops: latency 1; on accept, EX/MEM register loads on the next edge, mem_valid=1.
- MUL: FSM IDLE -> MUL on accept; operands latched; ex_busy=1 from the next cycle; DATA_W shift-add iterations, one per cycle; then DONE. Result = low DATA_W bits of the product (sign-agnostic). In DONE, if ~mem_stall, load the EX/MEM register, go to IDLE and deassert ex_busy the same edge; otherwise wait in DONE. While MUL/DONE, mem_valid=0 after the prior result drains.
- mem_stall=1: EX/MEM register holds all values; no accept; MUL keeps iterating.
- Without an accept and ~mem_stall: mem_valid goes 0 next edge (bubble); data fields are don't-care, controls forced 0.
- flush (synchronous, highest priority below reset): next edge mem_valid=0, wb_ctl_out=0, m_ctl_out=0, FSM->IDLE, ex_busy=0; the instruction offered the same cycle is dropped.
- A simultaneous flush and mem_stall resolves as flush.

Optional Feature:
EX_FWD_EN: adds ports fwd_a_sel in 2, fwd_b_sel in 2, fwd_mem_data in DATA_W, fwd_wb_data in DATA_W. Select 00=register file, 10=fwd_mem_data, 01=fwd_wb_data, 11=register file. The selection applies to rdata1 and to rdata2 before the ALUSrc mux; rdata2_out also uses forwarded B. Without the macro: no ports, operands come straight from rdata1/rdata2.

Test Plan:
- Reset mid-MUL: rst_n low at iteration 10 -> all outputs 0, ex_busy 0 immediately.
- ADD R-type: rdata1=5, rdata2=7, ALUOp=10, funct=100000, RegDst=1, rd=3 -> next edge alu_result=12, zero=0, dest_addr=3, mem_valid=1.
- BEQ: ALUOp=01, rdata1=rdata2=0x1234, npc=0x40, imm=0xFFFFFFFE -> zero=1, add_result=0x3E.
- SLT signed: rdata1=0xFFFFFFFF, rdata2=1 -> alu_result=1. ORI: ALUOp=11, ALUSrc=1, imm=0x00F0, rdata1=0x0F -> 0xFF.
- MUL 6*7 (DATA_W=32): ex_busy high for 32+ cycles; alu_result=42, mem_valid=1 once. 0xFFFFFFFF*2 -> 0xFFFFFFFE. mem_stall held during DONE -> result delayed and held, then loads once.
- Flush during MUL and with mem_stall=1 -> mem_valid=0, controls 0, FSM IDLE the next edge; with EX_FWD_EN, fwd_a_sel=10 and fwd_mem_data=100 plus rdata2=1 on ADD -> 101.
